// File: rtl/uart_pkg.sv
// Shared types, parity-mode encodings and the parity helper for the
// parametrised oversampling UART receiver.
package uart_pkg;

  // Widest data word the receiver supports; parity_calc takes this width.
  localparam int unsigned MAX_DATA_BITS = 9;

  // Parity mode encodings (PARITY_MODE parameter values).
  localparam int unsigned PAR_NONE = 0;
  localparam int unsigned PAR_EVEN = 1;
  localparam int unsigned PAR_ODD  = 2;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_e;

  // Error flags reported with each completed frame.
  typedef struct packed {
    logic frame_err;
    logic parity_err;
    logic overrun;
  } rx_flags_t;

  // Expected parity bit for a (zero-extended) data word; 0 when parity is off.
  function automatic logic parity_calc(input logic [MAX_DATA_BITS-1:0] data,
                                       input logic [1:0]               mode);
    logic p;
    p = ^data;
    case (mode)
      2'(PAR_EVEN): return p;
      2'(PAR_ODD):  return ~p;
      default:      return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/uart_rx_param_if.sv
// Consumer-side handshake of the UART receiver.
//   rdy_clr    : consumer acknowledge, clears rdy and all error flags
//   rdy        : frame available
//   data       : last received word (DATA_BITS wide)
//   frame_err  : stop bit sampled low in the last frame
//   parity_err : parity mismatch in the last frame
//   overrun    : frame completed while the previous one was unread (sticky)
// master = receiver side, slave = consumer side.
interface uart_rx_param_if #(
  parameter int unsigned DATA_BITS = 8
);

  logic                 rdy_clr;
  logic                 rdy;
  logic [DATA_BITS-1:0] data;
  logic                 frame_err;
  logic                 parity_err;
  logic                 overrun;

  modport master (
    input  rdy_clr,
    output rdy,
    output data,
    output frame_err,
    output parity_err,
    output overrun
  );

  modport slave (
    output rdy_clr,
    input  rdy,
    input  data,
    input  frame_err,
    input  parity_err,
    input  overrun
  );

endinterface

// File: rtl/uart_rx_sampler.sv
// Oversample counter and bit-decision strobes for the UART receiver.
// Ports:
//   clk_50m, rst  : clock and synchronous active-high reset
//   clken         : oversample tick
//   rx            : serial line
//   load_start    : on a tick, restart the count at 1 (start edge seen)
//   mid_stb_c     : tick on which the current bit value is decided
//   last_stb_c    : tick on the last sample of the bit period
//   bit_c         : decided bit value, valid with mid_stb_c
// UART_RX_MAJORITY_EN defined: bit value is the 2-of-3 vote of the samples at
// MID-1, MID and MID+1, decided at MID+1. Otherwise the single sample at MID.
module uart_rx_sampler #(
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic clk_50m,
  input  logic rst,
  input  logic clken,
  input  logic rx,
  input  logic load_start,
  output logic mid_stb_c,
  output logic last_stb_c,
  output logic bit_c
);

  localparam int unsigned CNT_W = $clog2(OVERSAMPLE);
  localparam int unsigned MID   = OVERSAMPLE / 2;

  logic [CNT_W-1:0] sample_q;

  // Free-running sample counter; wraps naturally at each bit boundary.
  always_ff @(posedge clk_50m) begin
    if (rst) begin
      sample_q <= '0;
    end else if (clken) begin
      if (load_start) begin
        sample_q <= CNT_W'(1);
      end else begin
        sample_q <= sample_q + CNT_W'(1);
      end
    end
  end

  assign last_stb_c = clken && (sample_q == CNT_W'(OVERSAMPLE - 1));

`ifdef UART_RX_MAJORITY_EN
  logic pre_q;
  logic mid_q;

  // Hold the two earlier votes; the third is the live line at MID+1.
  always_ff @(posedge clk_50m) begin
    if (rst) begin
      pre_q <= 1'b0;
      mid_q <= 1'b0;
    end else if (clken) begin
      if (sample_q == CNT_W'(MID - 1)) pre_q <= rx;
      if (sample_q == CNT_W'(MID))     mid_q <= rx;
    end
  end

  assign mid_stb_c = clken && (sample_q == CNT_W'(MID + 1));
  assign bit_c     = (pre_q & mid_q) | (pre_q & rx) | (mid_q & rx);
`else
  assign mid_stb_c = clken && (sample_q == CNT_W'(MID));
  assign bit_c     = rx;
`endif

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised oversampled UART receiver (start check, LSB-first data,
// optional parity, 1 or 2 stop bits) with a ready/clear handshake.
// Ports:
//   clk_50m : system clock
//   rst     : synchronous active-high reset, overrides clken
//   clken   : oversample tick, OVERSAMPLE pulses per bit period
//   rx      : serial line, idles high
//   bus     : uart_rx_param_if.master (rdy_clr in; rdy, data, flags out)
// Optional macro UART_RX_MAJORITY_EN selects 2-of-3 majority bit decisions
// one tick after mid-bit (see uart_rx_sampler).
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int unsigned DATA_BITS   = 8,
  parameter int unsigned OVERSAMPLE  = 16,
  parameter int unsigned PARITY_MODE = 0,
  parameter int unsigned STOP_BITS   = 1
) (
  input  logic clk_50m,
  input  logic rst,
  input  logic clken,
  input  logic rx,
  uart_rx_param_if.master bus
);

  localparam int unsigned BP_W = $clog2(DATA_BITS + 1);
  localparam int unsigned SC_W = 1;

  rx_state_e            state_q, state_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [BP_W-1:0]      bitpos_q, bitpos_d;
  logic [SC_W-1:0]      stopcnt_q, stopcnt_d;
  logic                 par_q, par_d;
  logic                 fpend_q, fpend_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 rdy_q, rdy_d;
  rx_flags_t            flags_q, flags_d;

  logic load_start_c;
  logic mid_stb_c;
  logic last_stb_c;
  logic bit_c;

  uart_rx_sampler #(
    .OVERSAMPLE (OVERSAMPLE)
  ) u_sampler (
    .clk_50m    (clk_50m),
    .rst        (rst),
    .clken      (clken),
    .rx         (rx),
    .load_start (load_start_c),
    .mid_stb_c  (mid_stb_c),
    .last_stb_c (last_stb_c),
    .bit_c      (bit_c)
  );

  // State and datapath registers.
  always_ff @(posedge clk_50m) begin
    if (rst) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      bitpos_q  <= '0;
      stopcnt_q <= '0;
      par_q     <= 1'b0;
      fpend_q   <= 1'b0;
      data_q    <= '0;
      rdy_q     <= 1'b0;
      flags_q   <= '0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bitpos_q  <= bitpos_d;
      stopcnt_q <= stopcnt_d;
      par_q     <= par_d;
      fpend_q   <= fpend_d;
      data_q    <= data_d;
      rdy_q     <= rdy_d;
      flags_q   <= flags_d;
    end
  end

  // Next-state, frame assembly and handshake.
  always_comb begin
    state_d      = state_q;
    shift_d      = shift_q;
    bitpos_d     = bitpos_q;
    stopcnt_d    = stopcnt_q;
    par_d        = par_q;
    fpend_d      = fpend_q;
    data_d       = data_q;
    rdy_d        = rdy_q;
    flags_d      = flags_q;
    load_start_c = 1'b0;

    // Acknowledge works on every clock; a completing frame below overrides it.
    if (bus.rdy_clr) begin
      rdy_d   = 1'b0;
      flags_d = '0;
    end

    if (clken) begin
      case (state_q)
        IDLE: begin
          if (!rx) begin
            state_d      = START;
            load_start_c = 1'b1;
          end
        end

        START: begin
          if (mid_stb_c && bit_c) begin
            state_d = IDLE;                 // false start
          end else if (last_stb_c) begin
            state_d  = DATA;
            bitpos_d = '0;
          end
        end

        DATA: begin
          if (mid_stb_c) begin
            for (int unsigned i = 0; i < DATA_BITS; i++) begin
              if (bitpos_q == BP_W'(i)) shift_d[i] = bit_c;
            end
            bitpos_d = bitpos_q + BP_W'(1);
          end else if (last_stb_c && (bitpos_q == BP_W'(DATA_BITS))) begin
            state_d   = (PARITY_MODE != PAR_NONE) ? PARITY : STOP;
            stopcnt_d = '0;
            fpend_d   = 1'b0;
          end
        end

        PARITY: begin
          if (mid_stb_c) begin
            par_d = bit_c;
          end else if (last_stb_c) begin
            state_d = STOP;
          end
        end

        STOP: begin
          if (stopcnt_q == SC_W'(STOP_BITS - 1)) begin
            // Last stop bit: finish at mid-bit so a closely following start
            // edge is not missed under baud mismatch.
            if (mid_stb_c) begin
              data_d             = shift_q;
              rdy_d              = 1'b1;
              flags_d.frame_err  = fpend_q | ~bit_c;
              flags_d.parity_err = (PARITY_MODE != PAR_NONE) &&
                                   (par_q != parity_calc(MAX_DATA_BITS'(shift_q),
                                                         2'(PARITY_MODE)));
              flags_d.overrun    = flags_q.overrun | (rdy_q & ~bus.rdy_clr);
              state_d            = IDLE;
            end
          end else begin
            if (mid_stb_c) begin
              fpend_d = fpend_q | ~bit_c;
            end else if (last_stb_c) begin
              stopcnt_d = stopcnt_q + SC_W'(1);
            end
          end
        end

        default: state_d = IDLE;
      endcase
    end
  end

  assign bus.rdy        = rdy_q;
  assign bus.data       = data_q;
  assign bus.frame_err  = flags_q.frame_err;
  assign bus.parity_err = flags_q.parity_err;
  assign bus.overrun    = flags_q.overrun;

endmodule

// File: tb/tb_uart_rx_param.sv
// Bench for uart_rx_param: three receivers (8N1, 8E2, 7O1) driven with
// directed and random frames, checked against a frame-level reference model.
module tb_uart_rx_param;

  localparam int unsigned OS = 16;
`ifdef UART_RX_MAJORITY_EN
  localparam int unsigned MIDOFF = OS / 2 + 1;
`else
  localparam int unsigned MIDOFF = OS / 2;
`endif

  logic clk_50m;
  logic rst;
  logic clken;
  logic clken_rand;
  logic rx0, rx1, rx2;

  int checks;
  int errors;

  uart_rx_param_if #(.DATA_BITS(8)) if0 ();
  uart_rx_param_if #(.DATA_BITS(8)) if1 ();
  uart_rx_param_if #(.DATA_BITS(7)) if2 ();

  uart_rx_param #(.DATA_BITS(8), .OVERSAMPLE(OS), .PARITY_MODE(0), .STOP_BITS(1)) u_dut0 (
    .clk_50m (clk_50m), .rst (rst), .clken (clken), .rx (rx0), .bus (if0)
  );
  uart_rx_param #(.DATA_BITS(8), .OVERSAMPLE(OS), .PARITY_MODE(1), .STOP_BITS(2)) u_dut1 (
    .clk_50m (clk_50m), .rst (rst), .clken (clken), .rx (rx1), .bus (if1)
  );
  uart_rx_param #(.DATA_BITS(7), .OVERSAMPLE(OS), .PARITY_MODE(2), .STOP_BITS(1)) u_dut2 (
    .clk_50m (clk_50m), .rst (rst), .clken (clken), .rx (rx2), .bus (if2)
  );

  // Reference model: what each consumer should currently see.
  logic       exp_rdy [3];
  logic       exp_fe  [3];
  logic       exp_pe  [3];
  logic       exp_ov  [3];
  logic [8:0] exp_data[3];
  logic       pend_fe [3];
  logic       pend_pe [3];
  logic [8:0] pend_data[3];

  function automatic int nbits(input int d);
    return (d == 2) ? 7 : 8;
  endfunction
  function automatic int pmode(input int d);
    return (d == 1) ? 1 : ((d == 2) ? 2 : 0);
  endfunction
  function automatic int nstop(input int d);
    return (d == 1) ? 2 : 1;
  endfunction

  function automatic logic [12:0] obs(input int d);
    case (d)
      0:       return {if0.rdy, if0.frame_err, if0.parity_err, if0.overrun, 9'(if0.data)};
      1:       return {if1.rdy, if1.frame_err, if1.parity_err, if1.overrun, 9'(if1.data)};
      default: return {if2.rdy, if2.frame_err, if2.parity_err, if2.overrun, 9'(if2.data)};
    endcase
  endfunction

  function automatic logic [12:0] expv(input int d);
    return {exp_rdy[d], exp_fe[d], exp_pe[d], exp_ov[d], exp_data[d]};
  endfunction

  initial begin
    clk_50m = 1'b0;
    forever #10 clk_50m = ~clk_50m;
  end

  initial begin
    forever begin
      @(posedge clk_50m);
      #1;
      clken = clken_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  initial begin
    #4_000_000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
    $fatal(1);
  end

  // Advance n oversample ticks, then settle just past the edge.
  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) begin
      do @(posedge clk_50m); while (clken !== 1'b1);
    end
    #1;
  endtask

  task automatic set_rx(input int d, input logic v);
    case (d)
      0:       rx0 = v;
      1:       rx1 = v;
      default: rx2 = v;
    endcase
  endtask

  task automatic send_bit(input int d, input logic v);
    set_rx(d, v);
    tick_n(OS);
  endtask

  task automatic model_reset();
    for (int d = 0; d < 3; d++) begin
      exp_rdy[d] = 0; exp_fe[d] = 0; exp_pe[d] = 0; exp_ov[d] = 0; exp_data[d] = '0;
    end
  endtask

  task automatic model_complete(input int d);
    exp_ov[d]   = exp_ov[d] | exp_rdy[d];
    exp_rdy[d]  = 1'b1;
    exp_data[d] = pend_data[d];
    exp_fe[d]   = pend_fe[d];
    exp_pe[d]   = pend_pe[d];
  endtask

  // One-clock acknowledge pulse, independent of clken.
  task automatic clr(input int d);
    case (d)
      0:       if0.rdy_clr = 1'b1;
      1:       if1.rdy_clr = 1'b1;
      default: if2.rdy_clr = 1'b1;
    endcase
    @(posedge clk_50m);
    #1;
    if0.rdy_clr = 1'b0; if1.rdy_clr = 1'b0; if2.rdy_clr = 1'b0;
    exp_rdy[d] = 0; exp_fe[d] = 0; exp_pe[d] = 0; exp_ov[d] = 0;
  endtask

  // Drive start, data, parity and all but the last stop bit; leaves rx at the
  // last stop value with no ticks of it elapsed.
  task automatic send_head(input int d, input logic [8:0] word, input logic par_bad,
                           input logic [1:0] stop_vals);
    logic [8:0] w;
    logic       pbit;
    int         ns;
    w  = word & 9'((1 << nbits(d)) - 1);
    ns = nstop(d);
    pbit = (($countones(w) % 2) == 1);          // bit making the total even
    if (pmode(d) == 2) pbit = ~pbit;
    pend_data[d] = w;
    pend_pe[d]   = (pmode(d) != 0) && par_bad;
    pend_fe[d]   = (stop_vals[0] == 1'b0) || ((ns == 2) && (stop_vals[1] == 1'b0));
    send_bit(d, 1'b0);
    for (int i = 0; i < nbits(d); i++) send_bit(d, w[i]);
    if (pmode(d) != 0) send_bit(d, pbit ^ par_bad);
    if (ns == 2) send_bit(d, stop_vals[0]);
    set_rx(d, stop_vals[ns - 1]);
  endtask

  task automatic send_tail(input int d);
    tick_n(OS - MIDOFF - 1);
    set_rx(d, 1'b1);
    tick_n(OS);
  endtask

  task automatic send_frame(input int d, input logic [8:0] word, input logic par_bad,
                            input logic [1:0] stop_vals);
    send_head(d, word, par_bad, stop_vals);
    tick_n(MIDOFF + 1);
    model_complete(d);
    send_tail(d);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk_50m);
    #1;
    model_reset();
    for (int d = 0; d < 3; d++) begin
      checks++;
      if (obs(d) !== expv(d)) begin
        errors++;
        $display("FAIL reset dut%0d got %h expected %h", d, obs(d), expv(d));
      end
    end
    rst = 1'b0;
    tick_n(4);
  endtask

  task automatic test_basic_8n1();
    clken_rand = 1'b0;
    tick_n(2);
    send_head(0, 9'h0A5, 1'b0, 2'b11);
    tick_n(MIDOFF);
    checks++;
    if (obs(0) !== expv(0)) begin
      errors++;
      $display("FAIL early_stop dut0 got %h expected %h", obs(0), expv(0));
    end
    tick_n(1);
    model_complete(0);
    checks++;
    if (obs(0) !== expv(0)) begin
      errors++;
      $display("FAIL a5_complete dut0 got %h expected %h", obs(0), expv(0));
    end
    send_tail(0);
    clr(0);
    checks++;
    if (obs(0) !== expv(0)) begin
      errors++;
      $display("FAIL a5_clear dut0 got %h expected %h", obs(0), expv(0));
    end
  endtask

  task automatic test_parity();
    clken_rand = 1'b1;
    clr(1);
    send_frame(1, 9'h007, 1'b1, 2'b11);
    checks++;
    if (obs(1) !== expv(1)) begin
      errors++;
      $display("FAIL par_bad dut1 got %h expected %h", obs(1), expv(1));
    end
    clr(1);
    send_frame(1, 9'h007, 1'b0, 2'b11);
    checks++;
    if (obs(1) !== expv(1)) begin
      errors++;
      $display("FAIL par_good dut1 got %h expected %h", obs(1), expv(1));
    end
  endtask

  task automatic test_stop_bits();
    clr(1);
    send_frame(1, 9'h03C, 1'b0, 2'b01);         // second stop bit low
    checks++;
    if (obs(1) !== expv(1)) begin
      errors++;
      $display("FAIL stop2_low dut1 got %h expected %h", obs(1), expv(1));
    end
    clr(1);
    send_frame(1, 9'h0C3, 1'b0, 2'b10);         // first stop bit low
    checks++;
    if (obs(1) !== expv(1)) begin
      errors++;
      $display("FAIL stop1_low dut1 got %h expected %h", obs(1), expv(1));
    end
    clr(0);
    send_frame(0, 9'h05A, 1'b0, 2'b00);
    checks++;
    if (obs(0) !== expv(0)) begin
      errors++;
      $display("FAIL stop_low dut0 got %h expected %h", obs(0), expv(0));
    end
  endtask

  task automatic test_false_start();
    clr(0);
    set_rx(0, 1'b0);
    tick_n(4);
    set_rx(0, 1'b1);
    tick_n(2 * OS);
    checks++;
    if (obs(0) !== expv(0)) begin
      errors++;
      $display("FAIL glitch dut0 got %h expected %h", obs(0), expv(0));
    end
    send_frame(0, 9'h055, 1'b0, 2'b11);
    checks++;
    if (obs(0) !== expv(0)) begin
      errors++;
      $display("FAIL after_glitch dut0 got %h expected %h", obs(0), expv(0));
    end
  endtask

  task automatic test_back_to_back();
    clr(0);
    send_frame(0, 9'h011, 1'b0, 2'b11);
    send_frame(0, 9'h022, 1'b0, 2'b11);
    checks++;
    if (obs(0) !== expv(0)) begin
      errors++;
      $display("FAIL overrun dut0 got %h expected %h", obs(0), expv(0));
    end
    clr(0);
    checks++;
    if (obs(0) !== expv(0)) begin
      errors++;
      $display("FAIL overrun_clr dut0 got %h expected %h", obs(0), expv(0));
    end
  endtask

  task automatic test_reset_midframe();
    send_bit(0, 1'b0);
    for (int i = 0; i < 3; i++) send_bit(0, 1'b1);
    rst = 1'b1;
    set_rx(0, 1'b1);
    @(posedge clk_50m);
    #1;
    model_reset();
    for (int d = 0; d < 3; d++) begin
      checks++;
      if (obs(d) !== expv(d)) begin
        errors++;
        $display("FAIL rst_mid dut%0d got %h expected %h", d, obs(d), expv(d));
      end
    end
    rst = 1'b0;
    tick_n(OS);
    send_frame(2, 9'h081, 1'b0, 2'b11);
    checks++;
    if (obs(2) !== expv(2)) begin
      errors++;
      $display("FAIL post_rst_81 dut2 got %h expected %h", obs(2), expv(2));
    end
    send_frame(0, 9'h0FF, 1'b0, 2'b11);
    checks++;
    if (obs(0) !== expv(0)) begin
      errors++;
      $display("FAIL post_rst_ff dut0 got %h expected %h", obs(0), expv(0));
    end
  endtask

  task automatic test_random();
    logic [8:0] w;
    logic       pb;
    logic [1:0] sv;
    clken_rand = 1'b1;
    for (int d = 0; d < 3; d++) begin
      for (int it = 0; it < 6; it++) begin
        w  = 9'($urandom);
        pb = ($urandom_range(0, 2) == 0);
        sv = {($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0)};
        if ($urandom_range(0, 1) == 1) clr(d);
        send_frame(d, w, pb, sv);
        checks++;
        if (obs(d) !== expv(d)) begin
          errors++;
          $display("FAIL random dut%0d iter%0d got %h expected %h", d, it, obs(d), expv(d));
        end
      end
    end
  endtask

  initial begin
    checks       = 0;
    errors       = 0;
    clken        = 1'b1;
    clken_rand   = 1'b0;
    rst          = 1'b1;
    rx0          = 1'b1;
    rx1          = 1'b1;
    rx2          = 1'b1;
    if0.rdy_clr  = 1'b0;
    if1.rdy_clr  = 1'b0;
    if2.rdy_clr  = 1'b0;
    model_reset();

    test_reset();
    test_basic_8n1();
    test_parity();
    test_stop_bits();
    test_false_start();
    test_back_to_back();
    test_reset_midframe();
    test_random();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_param.md
Name: uart_rx_param

Overview:
- Parametrised successor to the simulation UART receiver.
- Oversampled serial-to-parallel receiver with configurable data bits, parity, stop bits and oversample ratio.
- Validates start bits, reports framing, parity and overrun errors, and handles a ready/clear handshake.
- Used in simulation benches and SoC-level test harnesses to decode DUT UART TX lines. It sits behind a shared baud-tick (clken) generator.

Parameters:
- DATA_BITS, 8, data bits per frame, legal range 5..9, transmitted LSB first.
- OVERSAMPLE, 16, clken ticks per bit; power of two, minimum 8.
- PARITY_MODE, 0, 0 = none, 1 = even, 2 = odd.
- STOP_BITS, 1, number of stop bits, 1 or 2.

Ports:
- clk_50m  input  1  system clock; all logic on its rising edge.
- rst  input  1  synchronous, active-high reset.
- clken  input  1  oversample tick, OVERSAMPLE pulses per bit period.
- rx  input  1  serial line; idles high.
- rdy_clr  input  1  consumer acknowledge; clears rdy and all error flags.
- rdy  output  1  frame available.
- data  output  DATA_BITS  last received word.
- frame_err  output  1  stop bit sampled low in the last frame.
- parity_err  output  1  parity mismatch in the last frame; always 0 when PARITY_MODE = 0.
- overrun  output  1  new frame completed while rdy was still set and not being cleared (sticky).

Behaviour:
- Reset: synchronous, active-high, on clk_50m. It overrides clken.
  - rdy, frame_err, parity_err, overrun, data, shift register, counters all go to 0.
  - State goes to IDLE.
  - A partial frame in flight is discarded.
- State and counters only advance on cycles with clken = 1. rdy_clr is honoured on every cycle regardless of clken.
- Counters:
  - sample counter: $clog2(OVERSAMPLE) bits, wraps naturally.
  - MID = OVERSAMPLE/2.
  - bitpos: $clog2(DATA_BITS+1) bits.
- IDLE: on rx = 0, go to START with sample <= 1.
- START:
  - At sample == MID: if rx = 1, it is a false start. Return to IDLE with no flags and no rdy.
  - At sample == OVERSAMPLE-1: go to DATA with sample <= 0 and bitpos <= 0.
- DATA:
  - At sample == MID: shift[bitpos] <= rx; bitpos++.
  - At sample == OVERSAMPLE-1 with bitpos == DATA_BITS: go to PARITY if PARITY_MODE != 0, else STOP. sample <= 0, stopcnt <= 0.
- PARITY:
  - At MID: capture the parity bit.
  - At OVERSAMPLE-1: go to STOP.
  - Expected parity bit: even = XOR of the data bits; odd = its inverse.
- STOP, at MID:
  - If stopcnt < STOP_BITS-1: latch frame_err_pending |= !rx and continue. At OVERSAMPLE-1: stopcnt++, sample <= 0.
  - On the last stop bit, complete the frame on that MID tick. This deliberately ends half a bit early so the receiver can resync to a following start bit despite baud mismatch.
    - data <= shift.
    - rdy <= 1.
    - frame_err <= pending | !rx.
    - parity_err <= mismatch.
    - overrun <= overrun | (rdy & !rdy_clr).
    - Next state IDLE.
- Frame completion and rdy_clr on the same cycle: completion wins. rdy = 1 with the new flags; overrun is not set by this frame.
- rdy_clr alone clears rdy, frame_err, parity_err and overrun. data holds its value.
- A frame with frame_err still asserts rdy. The consumer decides whether to discard it.
- rx low held continuously: after a frame_err completion, IDLE sees rx = 0 and restarts. Each bit time that passes START validation is treated as a new frame (break condition). No special break detection.

Optional Feature:
- Macro: UART_RX_MAJORITY_EN.
- Defined: each bit value (start check, data, parity, stop) is the 2-of-3 majority of rx at sample MID-1, MID and MID+1. Capture and decisions occur at MID+1, and all MID-timed actions above shift to MID+1.
- Undefined: single sample at MID exactly as described above.

Decomposition:
- Package uart_pkg:
  - rx_state_e enum (IDLE, START, DATA, PARITY, STOP).
  - parity mode localparams PAR_NONE, PAR_EVEN, PAR_ODD.
  - Function parity_calc(data, mode) returning the expected parity bit.
- Sub-module uart_rx_sampler: sample counter, mid-point strobe generation, and majority vote. The FSM stays in the top level.

Test Plan:
- OVERSAMPLE=16, clken every cycle, 8N1, send 0xA5 -> rdy rises at the MID tick of the stop bit; data = 0xA5; all error flags 0.
- PARITY_MODE=1 (even), send 0x07 with parity bit 0 -> data = 0x07, parity_err = 1. Resend with parity bit 1 -> parity_err = 0.
- STOP_BITS=2, send 0x3C with the second stop bit forced low -> rdy = 1, data = 0x3C, frame_err = 1.
- rx low for 4 ticks then high (glitch) -> FSM returns to IDLE at MID; rdy stays 0. A following valid 0x55 is received correctly.
- Send 0x11 then 0x22 without asserting rdy_clr -> data = 0x22, overrun = 1. Pulse rdy_clr -> rdy, overrun = 0.
- Assert rst mid-way through the DATA bits of 0xFF -> all outputs 0 next cycle. A subsequent 0x81 is received cleanly, with DATA_BITS=7 giving data = 0x01.
